vga_timing: RTL
===============

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 The ports SHALL be as follows:
- clk  input  1  pixel clock, 65 MHz nominal; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- hcount  output  11  horizontal pixel counter, 0..1343.
- hsync  output  1  horizontal sync, active-high.
- hblnk  output  1  horizontal blanking, high outside visible columns.
- vcount  output  11  line counter, 0..805.
- vsync  output  1  vertical sync, active-high.
- vblnk  output  1  vertical blanking, high outside visible lines.
- frame_start  output  1  one-cycle pulse at pixel (0,0).
- frame_cnt  output  16  frames completed; present only with VGA_TIMING_FRAME_CNT_EN.
REQ-003 Every output SHALL be driven directly by a flip-flop, with no combinational path from any input.

Function
REQ-004 Timing SHALL be 1024x768 @ 60 Hz.
- Horizontal: 1344 total; visible 0..1023; sync 1048..1183; back porch to 1343.
- Vertical: 806 total; visible 0..767; sync 771..776; back porch to 805.
REQ-005 hcount SHALL increment by 1 each clk and SHALL wrap from 1343 to 0.
REQ-006 vcount SHALL increment only in the cycle where hcount wraps 1343->0, and SHALL wrap from 805 to 0 at that same edge when vcount=805.
REQ-007 Sync and blank flags SHALL be registered alongside the counters, so that they are valid in the same cycle as the count they describe.
- hblnk=1 iff hcount>=1024.
- hsync=1 iff 1048<=hcount<=1183.
- vblnk=1 iff vcount>=768.
- vsync=1 iff 771<=vcount<=776.
REQ-008 Next-state flag values SHALL be computed from the next-state counter values, so that the flags carry no one-cycle lag.
REQ-009 frame_start SHALL be 1 exactly in cycles where hcount=0 and vcount=0, except the first cycle after reset release.
REQ-010 One frame SHALL be 1344*806 = 1,083,264 clk cycles.
REQ-011 frame_start SHALL therefore pulse every 1,083,264 cycles.
REQ-012 Counter comparisons SHALL use full 11-bit unsigned width, with no truncation.

Reset
REQ-013 While rst=1 at a clk edge, all of the following SHALL be 0 after that edge: hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start, frame_cnt.
REQ-014 On the first edge with rst=0 after reset, hcount SHALL become 1 and vcount SHALL stay 0.
REQ-015 The first frame_start pulse after reset SHALL occur one full frame later.
REQ-016 Reset asserted mid-frame SHALL take effect at the next edge regardless of counter state, with no partial-line completion.

Configuration
REQ-017 With macro VGA_TIMING_FRAME_CNT_EN defined:
- frame_cnt output SHALL exist.
- frame_cnt SHALL increment by 1 in the same edge that sets frame_start=1.
- frame_cnt SHALL wrap 65535->0.
REQ-018 Without VGA_TIMING_FRAME_CNT_EN, the frame_cnt port and its register SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-019 Reset release: rst=1 for 4 cycles, then 0 -> after the first edge, hcount=1, vcount=0, hblnk=0, vblnk=0, hsync=0, vsync=0.
REQ-020 Line wrap: run to hcount=1343, vcount=0, then one edge -> hcount=0 and vcount=1 on that edge; hblnk 1->0.
REQ-021 H-sync window: over one line -> hsync=1 for exactly 136 cycles, first at hcount=1048, last at hcount=1183; hblnk=1 for exactly 320 cycles.
REQ-022 Frame wrap: run to hcount=1343, vcount=805, then one edge -> hcount=0, vcount=0, frame_start=1 for one cycle; vsync=1 lines counted = 6; next pulse 1,083,264 cycles later.
REQ-023 Mid-frame reset: at hcount=600, vcount=400 assert rst for 1 cycle -> all outputs 0 next edge; counting resumes from 0.
REQ-024 With VGA_TIMING_FRAME_CNT_EN: preload frame_cnt near wrap via 3 full frames from reset -> frame_cnt=3; forced state 65535 plus one frame -> frame_cnt=0.

Source files
------------

// File: rtl/vga_timing.sv
// 1024x768 @ 60 Hz VGA timing generator: pixel/line counters with registered sync, blank and frame-start flags.
// Optional frame counter output enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing (
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] hcount,
  output logic        hsync,
  output logic        hblnk,
  output logic [10:0] vcount,
  output logic        vsync,
  output logic        vblnk,
  output logic        frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam logic [10:0] H_TOTAL      = 11'd1344;
  localparam logic [10:0] H_VISIBLE    = 11'd1024;
  localparam logic [10:0] H_SYNC_START = 11'd1048;
  localparam logic [10:0] H_SYNC_END   = 11'd1183;
  localparam logic [10:0] V_TOTAL      = 11'd806;
  localparam logic [10:0] V_VISIBLE    = 11'd768;
  localparam logic [10:0] V_SYNC_START = 11'd771;
  localparam logic [10:0] V_SYNC_END   = 11'd776;

  logic [10:0] hcount_nxt;
  logic [10:0] vcount_nxt;
  logic        hsync_nxt;
  logic        hblnk_nxt;
  logic        vsync_nxt;
  logic        vblnk_nxt;
  logic        frame_start_nxt;

  // Flags are derived from the next counter values so they line up with the count they describe.
  always_comb begin
    hcount_nxt = hcount + 11'd1;
    vcount_nxt = vcount;
    if (hcount >= H_TOTAL - 11'd1) begin
      hcount_nxt = 11'd0;
      if (vcount >= V_TOTAL - 11'd1) begin
        vcount_nxt = 11'd0;
      end else begin
        vcount_nxt = vcount + 11'd1;
      end
    end
    hblnk_nxt       = (hcount_nxt >= H_VISIBLE);
    hsync_nxt       = (hcount_nxt >= H_SYNC_START) && (hcount_nxt <= H_SYNC_END);
    vblnk_nxt       = (vcount_nxt >= V_VISIBLE);
    vsync_nxt       = (vcount_nxt >= V_SYNC_START) && (vcount_nxt <= V_SYNC_END);
    frame_start_nxt = (hcount_nxt == 11'd0) && (vcount_nxt == 11'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount      <= 11'd0;
      vcount      <= 11'd0;
      hsync       <= 1'b0;
      hblnk       <= 1'b0;
      vsync       <= 1'b0;
      vblnk       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hcount      <= hcount_nxt;
      vcount      <= vcount_nxt;
      hsync       <= hsync_nxt;
      hblnk       <= hblnk_nxt;
      vsync       <= vsync_nxt;
      vblnk       <= vblnk_nxt;
      frame_start <= frame_start_nxt;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  // Counts completed frames, advancing on the same edge that raises frame_start; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= 16'd0;
    end else if (frame_start_nxt) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule
